// File: rtl/sb_rmw_unit.sv
// Store unit for a word-wide data memory.
// Store-word goes straight to a single write cycle. Store-byte reads the word
// first, waits RD_LAT cycles for the read data, replaces one byte lane and
// writes the merged word back. All memory-side outputs come from flops.
//
// Handshake: req is a strobe that is sampled only while the unit is idle
// (busy=0). The operands sb/sw/addr/busB are captured on that same edge and
// ignored afterwards. done pulses for one cycle after the write, and a new req
// may be presented in that cycle.
module sb_rmw_unit #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        sb,
  input  logic        sw,
  input  logic [31:0] addr,
  input  logic [31:0] busB,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_addr,
  output logic        dm_re,
  output logic        dm_we,
  output logic [31:0] dm_wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  // Counter value in the final read cycle.
  localparam logic [2:0] LAST_RD = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] merged;

  // Byte-lane merge of the captured store byte into the word read back.
  always_comb begin
    merged = dm_rdata;
    case (lane_q)
      2'd0:    merged[7:0]   = byte_q;
      2'd1:    merged[15:8]  = byte_q;
      2'd2:    merged[23:16] = byte_q;
      default: merged[31:24] = byte_q;
    endcase
  end

  // Next-state and next-output logic; strobes default low, captured data holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && sw) begin
          // sw wins when both qualifiers are set.
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = busB;
          we_d    = 1'b1;
          state_d = WR;
        end else if (req && sb) begin
          addr_d  = {addr[31:2], 2'b00};
          lane_d  = addr[1:0];
          byte_d  = busB[7:0];
          cnt_d   = 3'd0;
          re_d    = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        if (cnt_q == LAST_RD) begin
          wdata_d = merged;
          we_d    = 1'b1;
          state_d = WR;
        end else begin
          cnt_d = cnt_q + 3'd1;
          re_d  = 1'b1;
        end
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      lane_q  <= 2'd0;
      byte_q  <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dm_addr     = addr_q;
  assign dm_wdata    = wdata_q;
  assign dm_re       = re_q;
  assign dm_we       = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sb_rmw_unit.sv
// Bench for sb_rmw_unit: directed stores, a mid-read reset and a randomized
// sequence, checked by a monitor against a word-addressed memory model.
module tb_sb_rmw_unit;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        sb = 1'b0;
  logic        sw = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] busB = 32'd0;
  logic [31:0] dm_rdata = 32'd0;
  logic [31:0] dm_addr;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  sb_rmw_unit #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sb(sb), .sw(sw), .addr(addr),
    .busB(busB), .dm_rdata(dm_rdata), .dm_addr(dm_addr), .dm_re(dm_re),
    .dm_we(dm_we), .dm_wdata(dm_wdata), .busy(busy), .done(done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    bit          is_sb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [logic [29:0]];  // memory as the stores should leave it
  logic [31:0] mem     [logic [29:0]];  // memory as the DUT actually wrote it
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lane,
                                        input logic [7:0] b);
    logic [31:0] m;
    m = 32'hFF << (8 * lane);
    return (old & ~m) | ({24'd0, b} << (8 * lane));
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    ref_mem[a[31:2]] = v;
    mem[a[31:2]]     = v;
  endtask

  // Build the expected write for a store issued now and apply it to ref_mem.
  task automatic expect_store(input bit s_b, input bit s_w, input logic [31:0] a,
                              input logic [31:0] d);
    exp_t e;
    logic [29:0] w;
    w = a[31:2];
    if (!ref_mem.exists(w)) set_word(a, $urandom);
    e.addr = {a[31:2], 2'b00};
    if (s_w) begin
      e.data  = d;
      e.cyc   = cyc + 1;
      e.is_sb = 1'b0;
    end else begin
      e.data  = merge(ref_mem[w], a[1:0], d[7:0]);
      e.cyc   = cyc + 1 + RD_LAT;
      e.is_sb = 1'b1;
    end
    ref_mem[w] = e.data;
    exp_q.push_back(e);
  endtask

  // ---------------- memory responder ----------------
  // Read data is valid only in the RD_LAT-th consecutive dm_re cycle;
  // every other cycle carries junk so early or late sampling shows up.
  int rd_run = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n && dm_we) mem[dm_addr[31:2]] = dm_wdata;
    if (rst_n && dm_re) rd_run++;
    else rd_run = 0;
    if (rd_run == RD_LAT && mem.exists(dm_addr[31:2])) dm_rdata = mem[dm_addr[31:2]];
    else dm_rdata = $urandom;
  end

  // ---------------- monitor ----------------
  int re_run = 0;
  bit prev_we = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      re_run  = 0;
      prev_we = 1'b0;
    end else begin
      chk("re_we_exclusive", {31'd0, dm_re & dm_we}, 32'd0);
      chk("done_after_we", {31'd0, done}, {31'd0, prev_we});
      chk("busy_level", {31'd0, busy}, {31'd0, dm_re | dm_we});
      if (dm_re) begin
        if (re_run == 0) begin
          if (exp_q.size() == 0) begin
            chk("re_unexpected", {31'd0, dm_re}, 32'd0);
          end else begin
            chk("re_addr", dm_addr, exp_q[0].addr);
            chk("re_for_sb", {31'd0, exp_q[0].is_sb}, 32'd1);
            chk("re_start_cycle", 32'(cyc), 32'(exp_q[0].cyc - RD_LAT));
          end
        end
        re_run++;
      end else if (re_run != 0) begin
        chk("re_length", 32'(re_run), 32'(RD_LAT));
        re_run = 0;
      end
      if (dm_we) begin
        if (exp_q.size() == 0) begin
          chk("we_unexpected", {31'd0, dm_we}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("we_addr", dm_addr, e.addr);
          chk("we_data", dm_wdata, e.data);
          chk("we_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_we = dm_we;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Drives junk on every input while
  // busy and returns at the negedge of the done cycle (or one cycle later
  // for a request that should do nothing).
  task automatic do_store(input bit s_b, input bit s_w, input logic [31:0] a,
                          input logic [31:0] d);
    bit got;
    if (s_b || s_w) expect_store(s_b, s_w, a, d);
    req = 1'b1; sb = s_b; sw = s_w; addr = a; busB = d;
    @(negedge clk);
    if (s_b || s_w) begin
      got = 1'b0;
      for (int i = 0; i < RD_LAT + 4 && !got; i++) begin
        if (done) begin
          got = 1'b1;
        end else begin
          req  = 1'($urandom_range(0, 1));
          sb   = 1'($urandom_range(0, 1));
          sw   = 1'($urandom_range(0, 1));
          addr = $urandom;
          busB = $urandom;
          @(negedge clk);
        end
      end
      chk("done_seen", {31'd0, got}, 32'd1);
    end
    req = 1'b0; sb = 1'b0; sw = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_dm_addr"}, dm_addr, 32'd0);
    chk({tag, "_dm_wdata"}, dm_wdata, 32'd0);
    chk({tag, "_dm_re"}, {31'd0, dm_re}, 32'd0);
    chk({tag, "_dm_we"}, {31'd0, dm_we}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    int k;
    #1;
    check_outputs_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);

    // Store word, then store byte into lane 3 over a known word.
    do_store(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    set_word(32'h0000_0200, 32'h1122_3344);
    do_store(1'b1, 1'b0, 32'h0000_0203, 32'h0000_00AA);

    // Each lane over an all-ones word.
    for (int l = 0; l < 4; l++) begin
      set_word(32'h0000_0010, 32'hFFFF_FFFF);
      do_store(1'b1, 1'b0, 32'h0000_0010 + 32'(l), 32'h0000_0055);
    end

    // Back-to-back byte stores to one word (junk req driven during each).
    do_store(1'b1, 1'b0, 32'h0000_0041, 32'h0000_0012);
    do_store(1'b1, 1'b0, 32'h0000_0042, 32'h0000_0034);
    do_store(1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_F00D);

    // Request with no qualifier, then both qualifiers set.
    do_store(1'b0, 1'b0, 32'h0000_0080, 32'h1234_5678);
    @(negedge clk);
    do_store(1'b1, 1'b1, 32'h0000_0081, 32'hCAFE_0077);

    // Reset in the middle of a byte store's read phase.
    set_word(32'h0000_0300, 32'hA5A5_A5A5);
    expect_store(1'b1, 1'b0, 32'h0000_0301, 32'h0000_00EE);
    req = 1'b1; sb = 1'b1; sw = 1'b0; addr = 32'h0000_0301; busB = 32'h0000_00EE;
    @(negedge clk);
    req = 1'b0; sb = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    ref_mem[30'h0C0] = mem[30'h0C0];
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    do_store(1'b0, 1'b1, 32'h0000_0104, 32'h0102_0304);

    // Randomized stores over a small address window so words get reused.
    repeat (60) begin
      k = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 63));
      do_store(k[1], k[0] && (k != 2), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_rmw_unit.md
SB_RMW_UNIT -- requirements
Module: sb_rmw_unit

Interface
REQ-001 SHALL have parameter: RD_LAT, 1, data-memory read latency in cycles from dm_re assertion to dm_rdata valid (legal 1..4).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req  input  1  store request strobe; sampled only in IDLE.
REQ-005 SHALL have port: sb  input  1  store-byte opcode qualifier.
REQ-006 SHALL have port: sw  input  1  store-word opcode qualifier.
REQ-007 SHALL have port: addr  input  32  byte address of the store.
REQ-008 SHALL have port: busB  input  32  store data; sb uses busB[7:0] only.
REQ-009 SHALL have port: dm_rdata  input  32  data-memory read word.
REQ-010 SHALL have port: dm_addr  output  32  word-aligned memory address, {addr[31:2],2'b00}.
REQ-011 SHALL have port: dm_re  output  1  memory read enable.
REQ-012 SHALL have port: dm_we  output  1  memory write enable.
REQ-013 SHALL have port: dm_wdata  output  32  memory write word.
REQ-014 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RD, WR; all outputs registered.
REQ-017 In IDLE with req=1 and sw=1: SHALL capture dm_addr, dm_wdata=busB, go to WR (sw has priority when sb=sw=1).
REQ-018 In IDLE with req=1, sb=1, sw=0: SHALL capture dm_addr, lane=addr[1:0], byte=busB[7:0], clear wait counter, go to RD.
REQ-019 In IDLE with req=1 and sb=sw=0, or req=0: SHALL stay in IDLE, no memory access, no done.
REQ-020 In RD: dm_re=1 for exactly RD_LAT cycles; at the end of the last RD cycle SHALL sample dm_rdata and form the merged word, then go to WR.
REQ-021 Merge: lane 00 replaces bits 7:0, 01 bits 15:8, 10 bits 23:16, 11 bits 31:24; all other bits equal dm_rdata.
REQ-022 In WR: dm_we=1 for exactly one cycle with stable dm_addr/dm_wdata; dm_re=0; next state IDLE.
REQ-023 done SHALL be high for exactly the one cycle after the WR cycle; a new req SHALL be accepted in that same cycle.
REQ-024 Latency, req sampled at edge 0: sw gives dm_we in cycle 1, done in cycle 2; sb gives dm_re in cycles 1..RD_LAT, dm_we in cycle RD_LAT+1, done in cycle RD_LAT+2.
REQ-025 req, sb, sw, addr and busB SHALL be ignored while busy=1; captured values SHALL NOT change mid-operation.
REQ-026 dm_re and dm_we SHALL never be high in the same cycle.
REQ-027 busy SHALL rise in the cycle after an accepted req and fall in the cycle done is high.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, wait counter 0, and all outputs to 0 (dm_addr, dm_wdata, dm_re, dm_we, busy, done).
REQ-029 Reset asserted mid-operation SHALL abandon the store: no dm_we and no done afterward.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept a req.

Verification
REQ-031 sw, addr=0x100, busB=0xDEADBEEF -> cycle 1: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF; cycle 2: done=1.
REQ-032 sb, RD_LAT=1, addr=0x203, busB=0x000000AA, dm_rdata=0x11223344 -> cycle 1: dm_re=1, dm_addr=0x200; cycle 2: dm_we=1, dm_wdata=0xAA223344; cycle 3: done=1.
REQ-033 sb over lanes 0..3 at 0x10..0x13, busB=0x55, dm_rdata=0xFFFFFFFF -> dm_wdata 0xFFFFFF55, 0xFFFF55FF, 0xFF55FFFF, 0x55FFFFFF.
REQ-034 sb with RD_LAT=3; second req pulsed during RD, then back-to-back req in the done cycle -> dm_re held exactly 3 cycles, mid-op req ignored, back-to-back req accepted, each store gets exactly one dm_we.
REQ-035 rst_n=0 during RD of an sb -> all outputs 0 at once, no dm_we or done afterward; next sw completes normally.
REQ-036 req=1 with sb=sw=0, and req with sb=sw=1 -> the first causes no activity; the second behaves exactly as sw (no dm_re).
